// File: rtl/fpu_unpack_pkg.sv
// fpu_unpack_pkg: shared format constants, class bit indices and stage-1 register layout
package fpu_unpack_pkg;
  typedef enum logic [1:0] {HALF = 2'b00, SINGLE = 2'b01, DOUBLE = 2'b10, RSVD = 2'b11} fmt_e;
  localparam int H_EXP_BITS = 5;
  localparam int H_FRAC_BITS = 10;
  localparam int H_BIAS = 15;
  localparam int S_EXP_BITS = 8;
  localparam int S_FRAC_BITS = 23;
  localparam int S_BIAS = 127;
  localparam int D_EXP_BITS = 11;
  localparam int D_FRAC_BITS = 52;
  localparam int D_BIAS = 1023;
  localparam int CL_ZERO = 0;
  localparam int CL_SUB = 1;
  localparam int CL_INF = 2;
  localparam int CL_QNAN = 3;
  localparam int CL_SNAN = 4;
  localparam int CL_ILL = 5;
  localparam int CLASS_W = 6;
  typedef struct packed {
    fmt_e fmt;
    logic sign;
    logic [D_EXP_BITS-1:0] expRaw;
    logic [CLASS_W-1:0] cls;
  } s1_t;
  function automatic logic [D_EXP_BITS-1:0] fmtBias(fmt_e f);
    return f == HALF ? D_EXP_BITS'(H_BIAS) : f == SINGLE ? D_EXP_BITS'(S_BIAS) : D_EXP_BITS'(D_BIAS);
  endfunction
endpackage

// File: rtl/fpu_unpack_pipe_lzc.sv
// fpu_unpack_pipe_lzc: leading-zero counter; an all-zero input counts as W
module fpu_unpack_pipe_lzc #(
  parameter int W = 64,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  a,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++)
      if (a[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fpu_unpack_pipe.sv
// fpu_unpack_pipe: two-stage unpacker turning packed half/single/double into sign, unbiased exponent, normalised mantissa and class
module fpu_unpack_pipe
  import fpu_unpack_pkg::*;
#(
  parameter int MANT_W = 64,
  parameter int EXP_W = 13,
  parameter int TAG_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ftz,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [63:0]       in_bits,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_fmt,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic [5:0]        out_class,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int FW = MANT_W - 1;
  localparam int LZW = $clog2(MANT_W) + 1;
  fmt_e inFmt;
  logic inSign, expOnes, fracNz, expZero, isSub;
  logic [D_EXP_BITS-1:0] inExp;
  logic [FW-1:0] inFrac;
  s1_t s1d, s1q;
  logic s1Valid, s2Valid, s2Ready;
  logic [FW-1:0] s1Frac;
  logic [TAG_W-1:0] s1Tag;
  logic [LZW-1:0] lz;
  logic isNorm, isSpec;
  logic signed [15:0] biasS, eNorm, eSub;
  logic [MANT_W-1:0] subMant, nMant;
  logic [EXP_W-1:0] nExp;
  always_comb begin
    inFmt = fmt_e'(in_fmt);
    inSign = inFmt == HALF ? in_bits[H_FRAC_BITS + H_EXP_BITS] :
             inFmt == SINGLE ? in_bits[S_FRAC_BITS + S_EXP_BITS] : in_bits[D_FRAC_BITS + D_EXP_BITS];
    inExp = inFmt == HALF ? D_EXP_BITS'(in_bits[H_FRAC_BITS +: H_EXP_BITS]) :
            inFmt == SINGLE ? D_EXP_BITS'(in_bits[S_FRAC_BITS +: S_EXP_BITS]) : in_bits[D_FRAC_BITS +: D_EXP_BITS];
    expOnes = inFmt == HALF ? &in_bits[H_FRAC_BITS +: H_EXP_BITS] :
              inFmt == SINGLE ? &in_bits[S_FRAC_BITS +: S_EXP_BITS] : &in_bits[D_FRAC_BITS +: D_EXP_BITS];
    inFrac = inFmt == HALF ? {in_bits[H_FRAC_BITS-1:0], {(FW - H_FRAC_BITS){1'b0}}} :
             inFmt == SINGLE ? {in_bits[S_FRAC_BITS-1:0], {(FW - S_FRAC_BITS){1'b0}}} :
             {in_bits[D_FRAC_BITS-1:0], {(FW - D_FRAC_BITS){1'b0}}};
    fracNz = |inFrac;
    expZero = inExp == '0;
    isSub = expZero && fracNz;
    s1d.fmt = inFmt;
    s1d.sign = inFmt != RSVD && inSign;
    s1d.expRaw = inExp;
    s1d.cls = inFmt == RSVD ? CLASS_W'(1) << CL_ILL :
              {1'b0, expOnes && fracNz && !inFrac[FW-1], expOnes && inFrac[FW-1], expOnes && !fracNz,
               isSub && !ftz, expZero && (!fracNz || ftz)};
  end
  assign s2Ready = !s2Valid || out_ready;
  assign in_ready = !s1Valid || s2Ready;
  assign out_valid = s2Valid;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1Valid <= 1'b0;
      s1q <= '0;
      s1Frac <= '0;
      s1Tag <= '0;
    end else begin
      s1Valid <= !flush && (in_ready ? in_valid : s1Valid);
      if (in_valid && in_ready) begin
        s1q <= s1d;
        // flushed subnormals and reserved encodings carry no fraction forward
        s1Frac <= inFmt == RSVD || (isSub && ftz) ? '0 : inFrac;
        s1Tag <= in_tag;
      end
    end
  fpu_unpack_pipe_lzc #(.W(MANT_W), .CW(LZW)) uLzc (.a({s1Frac, 1'b0}), .cnt(lz));
  always_comb begin
    isNorm = s1q.cls == '0;
    isSpec = |s1q.cls[CL_SNAN:CL_INF];
    biasS = $signed({5'd0, fmtBias(s1q.fmt)});
    eNorm = $signed({5'd0, s1q.expRaw}) - biasS;
    // 1 - bias - (lz + 1)
    eSub = -biasS - $signed(16'(lz));
    subMant = {s1Frac, 1'b0} << lz;
    nMant = s1q.cls[CL_SUB] ? subMant : isNorm || isSpec ? {1'b1, s1Frac} : '0;
    nExp = s1q.cls[CL_SUB] ? EXP_W'(eSub) : isNorm ? EXP_W'(eNorm) : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s2Valid <= 1'b0;
      out_fmt <= '0;
      out_sign <= 1'b0;
      out_exp <= '0;
      out_mant <= '0;
      out_class <= '0;
      out_tag <= '0;
    end else begin
      s2Valid <= !flush && (s2Ready ? s1Valid : s2Valid);
      if (s1Valid && s2Ready) begin
        out_fmt <= s1q.fmt;
        out_sign <= s1q.sign;
        out_exp <= nExp;
        out_mant <= nMant;
        out_class <= s1q.cls;
        out_tag <= s1Tag;
      end
    end
endmodule

// File: tb/tb_fpu_unpack_pipe.sv
// tb_fpu_unpack_pipe: directed vectors for the operand unpacker, including stall, reset and flush behaviour
module tb_fpu_unpack_pipe;
  logic clk = 1'b0;
  logic reset, flush, ftz, in_valid, in_ready, out_valid, out_ready, out_sign;
  logic [1:0] in_fmt, out_fmt;
  logic [63:0] in_bits, out_mant;
  logic [5:0] in_tag, out_tag, out_class;
  logic [12:0] out_exp;
  int numCompared = 0;
  int numMismatched = 0;
  int sent, recv;

  fpu_unpack_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .ftz(ftz),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_bits(in_bits), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt), .out_sign(out_sign),
    .out_exp(out_exp), .out_mant(out_mant), .out_class(out_class), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] want);
    numCompared++;
    if (got !== want) begin
      numMismatched++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic runOne(input logic [1:0] f, input logic [63:0] b, input logic z, input logic [5:0] t);
    in_fmt = f;
    in_bits = b;
    ftz = z;
    in_tag = t;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    ftz = 1'b0;
    step;
    checkEq("valid", 64'(out_valid), 64'd1);
  endtask

  task automatic checkOut(input string n, input logic s, input int e, input logic [63:0] m, input logic [5:0] c, input logic [5:0] t);
    checkEq({n, ".sign"}, 64'(out_sign), 64'(s));
    checkEq({n, ".exp"}, 64'($signed(out_exp)), 64'(e));
    checkEq({n, ".mant"}, out_mant, m);
    checkEq({n, ".class"}, 64'(out_class), 64'(c));
    checkEq({n, ".tag"}, 64'(out_tag), 64'(t));
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    ftz = 1'b0;
    in_valid = 1'b0;
    in_fmt = 2'b00;
    in_bits = '0;
    in_tag = '0;
    out_ready = 1'b1;
    #1;
    checkEq("rst.out_valid", 64'(out_valid), 64'd0);
    checkEq("rst.out_mant", out_mant, 64'd0);
    checkEq("rst.out_class", 64'(out_class), 64'd0);
    repeat (2) step;
    reset = 1'b0;
    step;
    checkEq("rst.in_ready", 64'(in_ready), 64'd1);
    checkEq("rst.idle_valid", 64'(out_valid), 64'd0);

    runOne(2'b01, 64'h3F80_0000, 1'b0, 6'd1);
    checkOut("one", 1'b0, 0, 64'h8000_0000_0000_0000, 6'b000000, 6'd1);
    checkEq("one.fmt", 64'(out_fmt), 64'd1);
    runOne(2'b00, 64'h0001, 1'b0, 6'd2);
    checkOut("hsub", 1'b0, -24, 64'h8000_0000_0000_0000, 6'b000010, 6'd2);
    runOne(2'b00, 64'h0001, 1'b1, 6'd3);
    checkOut("hftz", 1'b0, 0, 64'h0, 6'b000001, 6'd3);
    runOne(2'b10, 64'h7FF0_0000_0000_0000, 1'b0, 6'd4);
    checkOut("dinf", 1'b0, 0, 64'h8000_0000_0000_0000, 6'b000100, 6'd4);
    runOne(2'b01, 64'h7F80_0001, 1'b0, 6'd5);
    checkOut("ssnan", 1'b0, 0, 64'h8000_0100_0000_0000, 6'b010000, 6'd5);
    runOne(2'b10, 64'hFFF8_0000_0000_0000, 1'b0, 6'd6);
    checkOut("dqnan", 1'b1, 0, 64'hC000_0000_0000_0000, 6'b001000, 6'd6);
    runOne(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd7);
    checkOut("rsvd", 1'b0, 0, 64'h0, 6'b100000, 6'd7);
    runOne(2'b10, 64'h0000_0000_0000_0001, 1'b0, 6'd8);
    checkOut("dmin", 1'b0, -1074, 64'h8000_0000_0000_0000, 6'b000010, 6'd8);
    runOne(2'b01, 64'h0060_0000, 1'b0, 6'd9);
    checkOut("sbigsub", 1'b0, -127, 64'hC000_0000_0000_0000, 6'b000010, 6'd9);
    runOne(2'b00, 64'h8000, 1'b0, 6'd10);
    checkOut("hnegzero", 1'b1, 0, 64'h0, 6'b000001, 6'd10);
    runOne(2'b10, 64'h7FEF_FFFF_FFFF_FFFF, 1'b0, 6'd11);
    checkOut("dmax", 1'b0, 1023, 64'hFFFF_FFFF_FFFF_F800, 6'b000000, 6'd11);
    step;

    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = cyc >= 3;
      in_valid = sent < 4;
      in_fmt = 2'b01;
      in_bits = 64'(32'h3F80_0000 + (sent << 23));
      in_tag = 6'(sent);
      #1;
      if (cyc == 2) checkEq("stall.in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        checkEq("stall.tag", 64'(out_tag), 64'(recv));
        checkEq("stall.exp", 64'($signed(out_exp)), 64'(recv));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      step;
    end
    in_valid = 1'b0;
    checkEq("stall.sent", 64'(sent), 64'd4);
    checkEq("stall.recv", 64'(recv), 64'd4);
    checkEq("stall.drained", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    in_fmt = 2'b01;
    in_bits = 64'h4000_0000;
    in_tag = 6'd20;
    step;
    in_tag = 6'd21;
    step;
    in_valid = 1'b0;
    checkEq("rstfly.pre_valid", 64'(out_valid), 64'd1);
    #3 reset = 1'b1;
    #1;
    checkEq("rstfly.async_valid", 64'(out_valid), 64'd0);
    checkEq("rstfly.async_mant", out_mant, 64'd0);
    step;
    step;
    reset = 1'b0;
    out_ready = 1'b1;
    step;
    step;
    checkEq("rstfly.stale", 64'(out_valid), 64'd0);
    checkEq("rstfly.in_ready", 64'(in_ready), 64'd1);

    out_ready = 1'b0;
    in_valid = 1'b1;
    in_tag = 6'd30;
    step;
    in_tag = 6'd31;
    step;
    checkEq("flush.pre_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    in_tag = 6'd32;
    step;
    flush = 1'b0;
    in_valid = 1'b0;
    checkEq("flush.valid", 64'(out_valid), 64'd0);
    step;
    checkEq("flush.dropped", 64'(out_valid), 64'd0);
    runOne(2'b00, 64'hC000, 1'b0, 6'd33);
    checkOut("postflush", 1'b1, 1, 64'h8000_0000_0000_0000, 6'b000000, 6'd33);
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end
endmodule
